// File: rtl/sseg_pkg.sv
// Shared types, segment patterns and helpers for the multiplexed seven-segment controller.
package sseg_pkg;

  // Active-high segment patterns in {g,f,e,d,c,b,a} order, indexed by nibble value.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  localparam logic [6:0] SEG_DASH = 7'h40;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_t;

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with valid/ready input handshake.
module bin2bcd_seq
  import sseg_pkg::*;
#(
  parameter int unsigned BIN_W      = 14,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BIN_W-1:0]        num_in,
  input  logic                    num_valid,
  output logic                    num_ready,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    ovf,
  output logic                    commit
);

  // Working register is wide enough for any BIN_W value, even if fewer digits are shown.
  localparam int unsigned BCD_DIGITS = ((BIN_W + 2) / 3 > NUM_DIGITS) ? (BIN_W + 2) / 3 : NUM_DIGITS;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
  localparam int unsigned CNT_W      = $clog2(BIN_W + 1);
  localparam logic [63:0] LIMIT      = pow10(NUM_DIGITS);

  conv_state_t              state_q, state_next;
  logic [BIN_W-1:0]         bin_q;
  logic [BCD_W-1:0]         bcd_q, bcd_adj;
  logic [BCD_W+BIN_W-1:0]   shifted;
  logic [CNT_W-1:0]         cnt_q;
  logic                     ovf_q;
  logic                     accept;

  assign num_ready = (state_q == IDLE) && !rst;
  assign accept    = num_valid && num_ready;
  assign commit    = (state_q == COMMIT);
  assign bcd       = bcd_q[4*NUM_DIGITS-1:0];
  assign ovf       = ovf_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    shifted = {bcd_adj, bin_q} << 1;
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(BIN_W - 1)) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_next;
      case (state_q)
        IDLE: if (accept) begin
          bin_q <= num_in;
          bcd_q <= '0;
          cnt_q <= '0;
          ovf_q <= 64'(num_in) >= LIMIT;
        end
        SHIFT: begin
          {bcd_q, bin_q} <= shifted;
          cnt_q          <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sseg_mux_ctrl.sv
// N-digit multiplexed seven-segment controller with handshaked binary load.
// Optional leading-zero blanking is enabled by defining SSEG_LZB_EN.
module sseg_mux_ctrl
  import sseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned BIN_W          = 14,
  parameter int unsigned SCAN_DIV       = 20000,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  parameter bit          CAT_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      num_in,
  input  logic                  num_valid,
  output logic                  num_ready,
  input  logic [NUM_DIGITS-1:0] dig_en,
  input  logic [NUM_DIGITS-1:0] dp_en,
  output logic                  ovf,
  output logic [NUM_DIGITS-1:0] an,
  output logic [7:0]            cat
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PRE_W = $clog2(SCAN_DIV);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};
  localparam logic [7:0]            CAT_OFF = {8{CAT_ACTIVE_LOW}};

  logic [4*NUM_DIGITS-1:0] conv_bcd, disp_q;
  logic                    conv_ovf, commit, ovf_q;
  logic [NUM_DIGITS-1:0]   lzb_mask;
  logic [PRE_W-1:0]        pre_q;
  logic [IDX_W-1:0]        idx_q;
  logic [NUM_DIGITS-1:0]   an_raw, an_q;
  logic [7:0]              cat_raw, cat_q;

  bin2bcd_seq #(
    .BIN_W      (BIN_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_conv (
    .clk       (clk),
    .rst       (rst),
    .num_in    (num_in),
    .num_valid (num_valid),
    .num_ready (num_ready),
    .bcd       (conv_bcd),
    .ovf       (conv_ovf),
    .commit    (commit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q <= '0;
      ovf_q  <= 1'b0;
    end else if (commit) begin
      disp_q <= conv_bcd;
      ovf_q  <= conv_ovf;
    end
  end

`ifdef SSEG_LZB_EN
  logic [NUM_DIGITS-1:0] lzb_q, lzb_next;

  // Digit k stays lit if it or any higher digit is non-zero; digit 0 always lit.
  always_comb begin
    lzb_next = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      for (int unsigned j = k; j < NUM_DIGITS; j++) begin
        if (conv_bcd[4*j +: 4] != 4'd0) lzb_next[k] = 1'b1;
      end
    end
    lzb_next[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)         lzb_q <= NUM_DIGITS'(1);
    else if (commit) lzb_q <= lzb_next;
  end

  assign lzb_mask = ovf_q ? '1 : lzb_q;
`else
  assign lzb_mask = '1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      idx_q <= '0;
    end else if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
      pre_q <= '0;
      idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  always_comb begin
    an_raw  = '0;
    cat_raw = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k) && dig_en[k] && lzb_mask[k]) begin
        an_raw[k]    = 1'b1;
        cat_raw[7]   = dp_en[k];
        cat_raw[6:0] = ovf_q ? SEG_DASH : SEG_HEX[disp_q[4*k +: 4]];
      end
    end
  end

  // Polarity is folded in by XOR with the inactive level.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q  <= AN_OFF;
      cat_q <= CAT_OFF;
    end else begin
      an_q  <= an_raw ^ AN_OFF;
      cat_q <= cat_raw ^ CAT_OFF;
    end
  end

  assign an  = an_q;
  assign cat = cat_q;
  assign ovf = ovf_q;

endmodule
